// File: rtl/serial_subtractor_if.sv
// Request/response bundle for the serial subtract/add unit: operands and start from the
// requester, busy/done and the registered result flags back from the unit.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, mode, a, b, bin,
        input  busy, done, d, bout, zero, ovf
    );

    modport slave (
        input  start, mode, a, b, bin,
        output busy, done, d, bout, zero, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial a-b-bin / a+b+bin with borrow/carry, zero and signed-overflow flags.
// Latency: WIDTH/DIGIT cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; a new request is accepted in the done cycle.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             a_msb;
    logic             b_msb;
    logic             mode_r;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             zero_r;
    logic             ovf_r;

    logic [DIGIT-1:0] dig;
    logic             chain_c;
    logic             brw_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             ovf_nxt;

    // DIGIT chained one-bit cells; the same sum bit serves both modes, only the
    // borrow/carry generate term differs.
    always_comb begin
        chain_c = brw;
        dig     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_sr[i] ^ b_sr[i] ^ chain_c;
            if (mode_r)
                chain_c = (a_sr[i] & b_sr[i]) | (chain_c & (a_sr[i] ^ b_sr[i]));
            else
                chain_c = (~a_sr[i] & b_sr[i]) | (chain_c & ~(a_sr[i] ^ b_sr[i]));
        end
        brw_nxt = chain_c;
    end

    // New digit enters from the MSB side so the last digit lands the word in place.
    assign res_nxt = (res_sr >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
    assign ovf_nxt = mode_r ? ((a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb))
                            : ((a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            mode_r <= 1'b0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            d_r    <= '0;
            bout_r <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        mode_r <= bus.mode;
                        brw    <= bus.bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_nxt;
                    brw    <= brw_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        d_r    <= res_nxt;
                        bout_r <= brw_nxt;
                        zero_r <= (res_nxt == '0);
                        ovf_r  <= ovf_nxt;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8))  bus8  ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for done on the 8-bit unit; returns edges counted after the start edge.
    task automatic wait_done8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus8.done && cyc < 30);
    endtask

    task automatic wait_done16(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus16.done && cyc < 30);
    endtask

    task automatic start8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        bus8.mode  = m;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    task automatic op16(input logic m, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output int cyc);
        @(negedge clk);
        bus16.mode  = m;
        bus16.a     = a;
        bus16.b     = b;
        bus16.bin   = bin;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        wait_done16(cyc);
    endtask

    initial begin
        int         cyc;
        int         cnt_hi;
        int         ndone;
        int         last;
        int         overlap;
        logic [7:0] exp_d;
        logic [16:0] full;
        logic [15:0] ra, rb, md;
        logic        rbin, mov;

        checks = 0;
        errors = 0;

        vecs[0] = '{1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.bin  = 1'b0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst8_outputs", 32'({bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.zero, bus8.ovf}), 32'd0);
        check("rst16_outputs", 32'({bus16.busy, bus16.done, bus16.d, bus16.bout, bus16.zero, bus16.ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_hi = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus8.busy || bus8.done || bus16.busy || bus16.done) cnt_hi++;
        end
        check("idle_no_activity", 32'(cnt_hi), 32'd0);

        // Table-driven 8-bit vectors
        for (int i = 0; i < 10; i++) begin
            start8(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("vec%0d_busy", i), 32'(bus8.busy), 32'd1);
            wait_done8(cyc);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd8);
            check($sformatf("vec%0d_done_busy", i), 32'({bus8.done, bus8.busy}), 32'b10);
            check($sformatf("vec%0d_d", i), 32'(bus8.d), 32'(vecs[i].d));
            check($sformatf("vec%0d_bout", i), 32'(bus8.bout), 32'(vecs[i].bout));
            check($sformatf("vec%0d_zero", i), 32'(bus8.zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d_ovf", i), 32'(bus8.ovf), 32'(vecs[i].ovf));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(bus8.done), 32'd0);
        end

        // start pulse and operand changes during RUN are ignored
        start8(1'b0, 8'h50, 8'h20, 1'b0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) begin
                bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.mode = 1'b1;
            end
            if (cyc == 4) bus8.start = 1'b0;
        end while (!bus8.done && cyc < 30);
        check("disturb_latency", 32'(cyc), 32'd8);
        check("disturb_d", 32'({bus8.d, bus8.bout}), 32'({8'h30, 1'b0}));
        @(posedge clk); #1;
        check("disturb_idle", 32'({bus8.busy, bus8.done}), 32'd0);

        // start held high: back-to-back results every N+1 cycles
        @(negedge clk);
        bus8.mode = 1'b0; bus8.a = 8'h09; bus8.b = 8'h04; bus8.bin = 1'b0; bus8.start = 1'b1;
        ndone = 0; last = 0; overlap = 0;
        for (int c = 1; c <= 40 && ndone < 3; c++) begin
            @(posedge clk); #1;
            if (bus8.busy && bus8.done) overlap++;
            if (bus8.done) begin
                exp_d = 8'h05 + 8'(ndone);
                check($sformatf("b2b%0d_d", ndone), 32'(bus8.d), 32'(exp_d));
                check($sformatf("b2b%0d_interval", ndone), 32'(c - last), 32'd9);
                last = c;
                ndone++;
                bus8.a = bus8.a + 8'd1;
                if (ndone == 3) bus8.start = 1'b0;
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        check("b2b_busy_done_overlap", 32'(overlap), 32'd0);
        @(posedge clk); #1;
        check("b2b_back_to_idle", 32'({bus8.busy, bus8.done}), 32'd0);

        // Reset in cycle 4 of RUN
        start8(1'b0, 8'h20, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(bus8.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({bus8.busy, bus8.done, bus8.d, bus8.bout, bus8.zero, bus8.ovf}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_hi = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) cnt_hi++;
        end
        check("abort_no_done", 32'(cnt_hi), 32'd0);

        // 16-bit unit, 4 bits per cycle
        op16(1'b0, 16'h1234, 16'h0235, 1'b0, cyc);
        check("w16_latency", 32'(cyc), 32'd4);
        check("w16_d", 32'(bus16.d), 32'h0FFF);
        check("w16_flags", 32'({bus16.bout, bus16.zero, bus16.ovf}), 32'd0);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                ra   = 16'($urandom);
                rb   = 16'($urandom);
                rbin = 1'($urandom_range(1));
                if (m == 1) full = {1'b0, ra} + {1'b0, rb} + 17'(rbin);
                else        full = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
                md  = full[15:0];
                mov = (m == 1) ? ((ra[15] == rb[15]) && (md[15] != ra[15]))
                               : ((ra[15] != rb[15]) && (md[15] != ra[15]));
                op16(1'(m), ra, rb, rbin, cyc);
                check($sformatf("rnd_m%0d_%0d_%h_%h_%0d", m, i, ra, rb, rbin),
                      32'({cyc[7:0], bus16.d, bus16.bout, bus16.zero, bus16.ovf}),
                      32'({8'd4, md, full[16], (md == 16'd0), mov}));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
